// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch port
// and the memory controller; hits are served combinationally, misses fill one word.
module icache #(
    parameter int NSETS = 16,
    parameter int IDX_W = $clog2(NSETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [NSETS-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [NSETS];
    logic [31:0]       r_data [NSETS];
    logic [31:0]       r_miss_addr;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_miss_tag;
    logic [IDX_W-1:0]  w_miss_idx;
    logic              w_hit;
    logic              w_start;
    logic              w_fill;

    assign w_tag      = imemaddr[31:2+IDX_W];
    assign w_idx      = imemaddr[1+IDX_W:2];
    assign w_miss_tag = r_miss_addr[31:2+IDX_W];
    assign w_miss_idx = r_miss_addr[1+IDX_W:2];

    assign w_hit   = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_start = (r_state == IDLE) & imemREN & ~w_hit & ~flush;
    assign w_fill  = (r_state == MISS) & ~iwait;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = MISS;
            MISS:    if (!iwait) w_next = FILL;
            FILL:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        imemload = 32'd0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        // A flush cycle never reports a hit, even if the line is still valid.
        if (r_state == IDLE && w_hit && !flush) begin
            ihit     = 1'b1;
            imemload = r_data[w_idx];
        end
        if (r_state == MISS) begin
            iREN  = 1'b1;
            iaddr = r_miss_addr;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_miss_addr <= 32'd0;
        end else if (w_start) begin
            r_miss_addr <= {imemaddr[31:2], 2'b00};
        end
    end

    // Flush wins over a coincident fill so the freshly filled line stays invalid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_miss_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_miss_idx]  <= w_miss_tag;
            r_data[w_miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: stimulus pushes expected misses/hits into queues,
// a negedge monitor pops and compares whenever the cache reads memory or hits.
module tb_icache;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          issue;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'd0;
    logic        flush;
    logic        tb_flush;
    logic        fill_flush = 1'b0;

    assign flush = tb_flush | fill_flush;

    icache #(.NSETS(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .flush    (flush)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    exp_t        hit_q[$];
    logic [31:0] miss_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          hits_seen = 0;
    int          mem_lat = 2;
    bit          flush_arm = 1'b0;
    bit          prev_iren = 1'b0;
    logic [31:0] cur_miss = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_000A;
            32'h0000_0040: return 32'hDEAD_BEEF;
            default:       return 32'h1000_0000 | a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- memory responder ----------------
    int  mem_cnt = 0;
    bit  arm_done = 1'b0;
    always @(negedge CLK) begin
        fill_flush = 1'b0;
        if (!iREN) begin
            mem_cnt = 0;
            iwait   = 1'b1;
            iload   = 32'd0;
        end else if (mem_cnt < mem_lat) begin
            mem_cnt++;
            iwait = 1'b1;
        end else begin
            iwait   = 1'b0;
            iload   = mem_word(iaddr);
            mem_cnt = 0;
            if (flush_arm && !arm_done) begin
                fill_flush = 1'b1;
                arm_done   = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (RST) begin
            prev_iren = 1'b0;
        end else begin
            if (iREN) begin
                if (!prev_iren) begin
                    if (miss_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_miss: iaddr=%h, required no memory read (t=%0t)", iaddr, $time);
                        cur_miss = iaddr;
                    end else begin
                        cur_miss = miss_q.pop_front();
                        chk("miss_addr", iaddr, cur_miss);
                    end
                end else begin
                    chk("iaddr_held", iaddr, cur_miss);
                end
            end else begin
                chk("iaddr_idle", iaddr, 32'd0);
            end
            prev_iren = iREN;
            if (ihit) begin
                hits_seen++;
                if (hit_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_hit: imemload=%h, required ihit=0 (t=%0t)", imemload, $time);
                end else begin
                    exp_t e;
                    e = hit_q.pop_front();
                    chk("hit_data", imemload, e.data);
                    chk("hit_latency", 32'(cyc - e.issue), 32'(e.lat));
                end
            end else begin
                chk("imemload_nohit", imemload, 32'd0);
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_hit(input int seen);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            if (hits_seen != seen) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            n_checks++;
            $display("FAIL fetch_timeout: addr=%h got no ihit, required ihit within 200 cycles", imemaddr);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
        exp_t e;
        int   seen;
        e.data  = d;
        e.lat   = lat;
        e.issue = cyc;
        hit_q.push_back(e);
        seen     = hits_seen;
        imemREN  = 1'b1;
        imemaddr = a;
        wait_hit(seen);
        imemREN  = 1'b0;
    endtask

    task automatic miss_fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
        miss_q.push_back({a[31:2], 2'b00});
        fetch(a, d, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        int   seen;
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        tb_flush = 1'b0;
        #2;
        chk("reset_ihit", {31'd0, ihit}, 32'd0);
        chk("reset_iREN", {31'd0, iREN}, 32'd0);
        chk("reset_iaddr", iaddr, 32'd0);
        chk("reset_imemload", imemload, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // cold miss, latency 2 -> ihit 5 cycles after the miss is presented
        mem_lat = 2;
        miss_fetch(32'h0000_0000, 32'h2001_000A, 5);
        fetch(32'h0000_0000, 32'h2001_000A, 0);
        fetch(32'h0000_0003, 32'h2001_000A, 0);

        // conflict eviction on index 0
        miss_fetch(32'h0000_0040, 32'hDEAD_BEEF, 5);
        miss_fetch(32'h0000_0000, 32'h2001_000A, 5);

        // zero-latency memory on the last index
        mem_lat = 0;
        miss_fetch(32'h0000_003C, 32'h1000_003C, 3);
        fetch(32'h0000_003C, 32'h1000_003C, 0);
        mem_lat = 2;

        // redirect while the 0x10 miss is waiting on memory
        miss_q.push_back(32'h0000_0010);
        miss_q.push_back(32'h0000_0100);
        e.data  = 32'h1000_0100;
        e.lat   = 10;
        e.issue = cyc;
        hit_q.push_back(e);
        seen     = hits_seen;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        repeat (2) @(posedge CLK);
        #1 imemaddr = 32'h0000_0100;
        wait_hit(seen);
        imemREN = 1'b0;
        fetch(32'h0000_0010, 32'h1000_0010, 0);
        fetch(32'h0000_0100, 32'h1000_0100, 0);

        // flush with several valid lines, coinciding with a would-be hit
        miss_fetch(32'h0000_0004, 32'h1000_0004, 5);
        miss_fetch(32'h0000_0008, 32'h1000_0008, 5);
        tb_flush = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0004;
        @(posedge CLK);
        #1;
        tb_flush = 1'b0;
        imemREN  = 1'b0;
        miss_fetch(32'h0000_0100, 32'h1000_0100, 5);
        miss_fetch(32'h0000_0010, 32'h1000_0010, 5);
        miss_fetch(32'h0000_003C, 32'h1000_003C, 5);
        miss_fetch(32'h0000_0004, 32'h1000_0004, 5);

        // flush on the fill edge: line stays invalid, so the fetch misses twice
        flush_arm = 1'b1;
        miss_q.push_back(32'h0000_0020);
        miss_fetch(32'h0000_0020, 32'h1000_0020, 10);
        fetch(32'h0000_0020, 32'h1000_0020, 0);

        // asynchronous reset in the middle of a miss
        mem_lat = 6;
        miss_q.push_back(32'h0000_0030);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0030;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_mid_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_mid_iaddr", iaddr, 32'd0);
        miss_q.delete();
        hit_q.delete();
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        imemREN = 1'b0;
        mem_lat = 2;
        miss_fetch(32'h0000_0000, 32'h2001_000A, 5);
        miss_fetch(32'h0000_0020, 32'h1000_0020, 5);

        repeat (2) @(posedge CLK);
        #1;
        chk("queues_drained", 32'(hit_q.size() + miss_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-block instruction cache.
- Sits between the datapath's instruction-fetch port and the memory controller's instruction port.
- Serves fetches combinationally on a hit and drives `ihit`, which gates the datapath pipeline registers.
- On a miss it issues a single-word read to memory, fills the line, then serves the fetch on the following cycle.

Parameters:
- NSETS, 16, number of cache lines; power of two, ≥2.
- IDX_W, $clog2(NSETS), index width.
- TAG_W, 30-IDX_W, tag width (addr[31:2+IDX_W]).

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- imemREN  input  1  datapath fetch request
- imemaddr  input  32  datapath fetch byte address; word aligned
- ihit  output  1  fetch satisfied this cycle; imemload valid
- imemload  output  32  instruction word returned to the datapath
- iREN  output  1  read request to the memory controller
- iaddr  output  32  word address of the outstanding memory read
- iwait  input  1  memory busy; data not yet valid
- iload  input  32  memory read data, valid when iREN & !iwait
- flush  input  1  synchronous invalidate of all lines

Behaviour:
- Address split:
  - tag = imemaddr[31:2+IDX_W]
  - idx = imemaddr[1+IDX_W:2]
  - imemaddr[1:0] ignored.
- Storage per line: valid bit, TAG_W tag, 32-bit data. Registers, no SRAM macro.
- Reset (async, RST=1): all valid bits 0, state=IDLE, miss_addr=0. Outputs at reset: ihit=0, iREN=0, iaddr=0, imemload=0.
- Hit detection (combinational): hit = imemREN & valid[idx] & (tagArr[idx]==tag).
  - ihit = hit while state==IDLE, else 0.
  - imemload = dataArr[idx] when ihit, else 0.
- FSM states: IDLE, MISS, FILL.
  - IDLE: if imemREN & !hit & !flush → MISS; latch miss_addr = {imemaddr[31:2],2'b00}. Otherwise stay.
  - MISS: iREN=1, iaddr=miss_addr. Stay while iwait=1. When iwait=0 → FILL; capture iload into the line at miss_addr's index, set valid, write tag.
  - FILL: one-cycle settle, iREN=0, ihit=0 → IDLE. The following cycle re-evaluates the hit against the current imemaddr.
- Miss latency: memory latency + 2 cycles from the first miss cycle to ihit.
- iaddr is held at miss_addr for the whole MISS state and is stable regardless of imemaddr changes. A redirect mid-miss (branch/jump changes imemaddr, or imemREN drops) does not abort the fill. The line for miss_addr is installed, and the new address is then looked up in IDLE.
- Replacement: direct-mapped overwrite of the indexed line. No dirty state (read-only cache).
- flush:
  - In IDLE: clears all valid bits at the next edge; ihit forced 0 that cycle.
  - In MISS/FILL: takes effect at the end of the fill. The fill's valid set is suppressed when flush and the fill edge coincide, so valid ends at 0.
- When iREN=0, iaddr=0.
- Simultaneous hit and flush in IDLE: ihit=0; no state change except invalidation.
- A fill to the line whose index matches the current fetch does not produce ihit in the same cycle (FILL state blocks it).

Test Plan:
- Reset then fetch 0x00000000, memory latency 2 (iwait=1 for 2 cycles, iload=0x2001000A) → iREN=1, iaddr=0x0 for 3 cycles; ihit=1 with imemload=0x2001000A 2 cycles after iwait drops.
- Refetch 0x00000000 → ihit=1 the same cycle, iREN stays 0, imemload=0x2001000A.
- Conflict: with 0x00000000 cached, fetch 0x00000040 (same index for NSETS=16) → miss, fill with 0xDEADBEEF; then refetch 0x00000000 → miss again (line evicted).
- Redirect mid-miss: miss on 0x00000010, change imemaddr to 0x00000100 while iwait=1 → iaddr stays 0x10 until the fill completes. Then a second miss is issued for 0x100, and 0x10 hits afterwards.
- flush asserted for 1 cycle with 4 lines valid → the next fetch to each of the 4 addresses misses. flush on the fill edge → that line is not valid.
- Assert RST mid-MISS → iREN=0, ihit=0 immediately (async); all lines invalid after release.
